// File: rtl/tff_bank.sv
// Bank of WIDTH T cells: hold/toggle/load/up-down count, 1-cycle registered latency, no backpressure.
// Optional `TFF_BANK_SYNC_CLR_EN adds i_clr, a synchronous clear to RESET_VAL that overrides every mode.
module tff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
`ifdef TFF_BANK_SYNC_CLR_EN
  input  logic             i_clr,
`endif
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_t,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_changed
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] cnt_t;
  logic             cnt_wrap;
  mode_e            mode;

  assign mode = mode_e'(i_mode);

  // Ripple T-chain: bit k toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    cnt_t    = '0;
    cnt_t[0] = 1'b1;
    for (int k = 1; k < WIDTH; k++) begin
      cnt_t[k] = cnt_t[k-1] & (i_up ? q_q[k-1] : ~q_q[k-1]);
    end
    cnt_wrap = cnt_t[WIDTH-1] & (i_up ? q_q[WIDTH-1] : ~q_q[WIDTH-1]);
  end

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (i_en) begin
      case (mode)
        MODE_HOLD:   q_d = q_q;
        MODE_TOGGLE: q_d = q_q ^ i_t;
        MODE_LOAD:   q_d = i_d;
        MODE_COUNT: begin
          q_d  = q_q ^ cnt_t;
          tc_d = cnt_wrap;
        end
        default:     q_d = q_q;
      endcase
    end
`ifdef TFF_BANK_SYNC_CLR_EN
    if (i_clr) begin
      q_d  = RESET_VAL;
      tc_d = 1'b0;
    end
`endif
    changed_d = |(q_d ^ q_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q       <= RESET_VAL;
      tc_q      <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      tc_q      <= tc_d;
      changed_q <= changed_d;
    end
  end

  assign o_q       = q_q;
  assign o_tc      = tc_q;
  assign o_changed = changed_q;

endmodule
